// File: rtl/usb_tx_shift_register.sv
// USB TX byte serializer feeding the bit stuffer: valid/ready byte intake through a
// one-byte holding register, LSB-first shift out on each unstuffed bit-time strobe.
module usb_tx_shift_register #(
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] tx_byte,
  input  logic              tx_byte_valid,
  input  logic              tx_last,
  output logic              tx_byte_ready,
  input  logic              rollover_flag64,
  input  logic              stuffing,
  output logic              serial_out,
  output logic              tx_active,
  output logic              tx_done,
  output logic              tx_underrun
);

  localparam int CNT_W = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r;
  logic [BYTE_W-1:0] hold_r;
  logic              hold_last_r;
  logic              hold_full_r;
  logic              last_pending_r;
  logic [BYTE_W-1:0] shifter_r;
  logic              last_q_r;
  logic [CNT_W-1:0]  bit_cnt_r;

  logic accept_s;
  logic adv_s;
  logic byte_end_s;
  logic drain_s;
  logic finish_s;
  logic hold_full_nxt_s;
  logic last_pending_nxt_s;

  // Handshake, advance qualification and next-cycle holding-register occupancy.
  always_comb begin
    accept_s   = tx_byte_valid && tx_byte_ready;
    adv_s      = rollover_flag64 && !stuffing && (state_r == SHIFT);
    byte_end_s = adv_s && (bit_cnt_r == CNT_LAST);
    // Hold drains either into LOAD or straight into the shifter on a gapless reload.
    drain_s    = (state_r == LOAD) || (byte_end_s && hold_full_r);
    finish_s   = byte_end_s && !hold_full_r;

    if (accept_s) begin
      hold_full_nxt_s = 1'b1;
    end else if (drain_s) begin
      hold_full_nxt_s = 1'b0;
    end else begin
      hold_full_nxt_s = hold_full_r;
    end

    if (accept_s && tx_last) begin
      last_pending_nxt_s = 1'b1;
    end else if (finish_s) begin
      last_pending_nxt_s = 1'b0;
    end else begin
      last_pending_nxt_s = last_pending_r;
    end
  end

  // Serializer FSM, holding register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      hold_r         <= '0;
      hold_last_r    <= 1'b0;
      hold_full_r    <= 1'b0;
      last_pending_r <= 1'b0;
      shifter_r      <= '0;
      last_q_r       <= 1'b0;
      bit_cnt_r      <= '0;
      serial_out     <= 1'b1;
      tx_active      <= 1'b0;
      tx_done        <= 1'b0;
      tx_underrun    <= 1'b0;
      tx_byte_ready  <= 1'b1;
    end else begin
      hold_full_r    <= hold_full_nxt_s;
      last_pending_r <= last_pending_nxt_s;
      tx_byte_ready  <= !hold_full_nxt_s && !last_pending_nxt_s;
      tx_done        <= 1'b0;
      tx_underrun    <= 1'b0;
      if (accept_s) begin
        hold_r      <= tx_byte;
        hold_last_r <= tx_last;
      end

      case (state_r)
        IDLE: begin
          serial_out <= 1'b1;
          tx_active  <= 1'b0;
          if (hold_full_r) begin
            state_r <= LOAD;
          end
        end
        LOAD: begin
          shifter_r  <= hold_r;
          last_q_r   <= hold_last_r;
          bit_cnt_r  <= '0;
          serial_out <= hold_r[0];
          tx_active  <= 1'b1;
          state_r    <= SHIFT;
        end
        SHIFT: begin
          if (adv_s) begin
            if (bit_cnt_r != CNT_LAST) begin
              shifter_r  <= shifter_r >> 1;
              serial_out <= shifter_r[1];
              bit_cnt_r  <= bit_cnt_r + CNT_W'(1);
            end else if (hold_full_r) begin
              shifter_r  <= hold_r;
              last_q_r   <= hold_last_r;
              bit_cnt_r  <= '0;
              serial_out <= hold_r[0];
            end else if (last_q_r) begin
              serial_out <= 1'b1;
              tx_active  <= 1'b0;
              tx_done    <= 1'b1;
              state_r    <= DONE;
            end else begin
              serial_out  <= 1'b1;
              tx_active   <= 1'b0;
              tx_underrun <= 1'b1;
              state_r     <= IDLE;
            end
          end
        end
        DONE: begin
          serial_out <= 1'b1;
          tx_active  <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          serial_out <= 1'b1;
          tx_active  <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_shift_register.sv
// Directed bench for usb_tx_shift_register: table of single-byte packets plus
// hand-written back-to-back, stuffing, ready-hold and mid-packet reset sequences.
module tb_usb_tx_shift_register;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_byte_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_byte_ready;
  logic       rollover_flag64 = 1'b0;
  logic       stuffing = 1'b0;
  logic       serial_out;
  logic       tx_active;
  logic       tx_done;
  logic       tx_underrun;

  usb_tx_shift_register #(.BYTE_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .tx_byte        (tx_byte),
    .tx_byte_valid  (tx_byte_valid),
    .tx_last        (tx_last),
    .tx_byte_ready  (tx_byte_ready),
    .rollover_flag64(rollover_flag64),
    .stuffing       (stuffing),
    .serial_out     (serial_out),
    .tx_active      (tx_active),
    .tx_done        (tx_done),
    .tx_underrun    (tx_underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [7:0] exp_bits;
    int         exp_done;
    int         exp_und;
  } vec_t;

  vec_t vecs[5];
  int n_vec = 0;
  int n_err = 0;

  // monitor state
  int          cyc = 0;
  int          adv_cnt = 0;
  int          nbits = 0;
  int          done_cnt = 0;
  int          und_cnt = 0;
  int          done_cyc = -1;
  int          last_adv_cyc = -1;
  int          strobes_act = 0;
  int          act_fall = 0;
  logic [31:0] stream = 32'h0;
  logic        und_ready = 1'b0;
  logic        stuff_bit = 1'b0;
  logic        prev_active = 1'b0;

  // strobe generator control
  int   scnt = 0;
  logic stuff_arm = 1'b0;
  int   stuff_at = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    adv_cnt = 0; nbits = 0; stream = 32'h0; done_cnt = 0; und_cnt = 0;
    done_cyc = -1; last_adv_cyc = -1; strobes_act = 0; act_fall = 0;
    und_ready = 1'b0; stuff_bit = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    int t;
    t = 0;
    @(posedge clk); #1;
    tx_byte = b; tx_last = l; tx_byte_valid = 1'b1;
    @(negedge clk);
    while (!tx_byte_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 within 500 cycles");
    end
    @(posedge clk); #1;
    tx_byte_valid = 1'b0;
  endtask

  task automatic wait_events(input int n);
    int t;
    t = 0;
    while ((done_cnt + und_cnt) < n && t < 2000) begin
      @(negedge clk); #1;
      t++;
    end
    if (t >= 2000) begin
      n_vec++; n_err++;
      $display("FAIL event_timeout: got %0d events expected %0d", done_cnt + und_cnt, n);
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  // Bit-time strobe every 8 cycles; optional single stuffed strobe after stuff_at advances.
  initial begin
    forever begin
      @(posedge clk); #1;
      scnt++;
      rollover_flag64 = (scnt % 8 == 0);
      stuffing = 1'b0;
      if (rollover_flag64 && stuff_arm && adv_cnt == stuff_at) begin
        stuffing  = 1'b1;
        stuff_arm = 1'b0;
      end
    end
  end

  // Serial monitor: records the bit on the line at every qualifying advance.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rollover_flag64 && tx_active) begin
        strobes_act++;
        if (stuffing) begin
          stuff_bit = serial_out;
        end else begin
          if (nbits < 32) stream[nbits] = serial_out;
          nbits++;
          adv_cnt++;
          last_adv_cyc = cyc;
        end
      end
      if (tx_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (tx_underrun) begin
        und_cnt++;
        und_ready = tx_byte_ready;
      end
      if (prev_active && !tx_active) act_fall++;
      prev_active = tx_active;
    end
  end

  initial begin
    logic early;
    int   t;

    vecs[0] = '{data: 8'hA5, last: 1'b1, exp_bits: 8'hA5, exp_done: 1, exp_und: 0};
    vecs[1] = '{data: 8'h01, last: 1'b0, exp_bits: 8'h01, exp_done: 0, exp_und: 1};
    vecs[2] = '{data: 8'h00, last: 1'b1, exp_bits: 8'h00, exp_done: 1, exp_und: 0};
    vecs[3] = '{data: 8'h80, last: 1'b1, exp_bits: 8'h80, exp_done: 1, exp_und: 0};
    vecs[4] = '{data: 8'h3C, last: 1'b0, exp_bits: 8'h3C, exp_done: 0, exp_und: 1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_serial_out", 32'(serial_out), 32'd1);
    check("rst_tx_active", 32'(tx_active), 32'd0);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    check("rst_tx_underrun", 32'(tx_underrun), 32'd0);
    check("rst_ready", 32'(tx_byte_ready), 32'd1);

    // single-byte packets from the table
    for (int i = 0; i < 5; i++) begin
      clear_mon();
      send_byte(vecs[i].data, vecs[i].last);
      wait_events(1);
      check("vec_bits", 32'(stream[7:0]), 32'(vecs[i].exp_bits));
      check("vec_nbits", 32'(nbits), 32'd8);
      check("vec_done", 32'(done_cnt), 32'(vecs[i].exp_done));
      check("vec_underrun", 32'(und_cnt), 32'(vecs[i].exp_und));
      if (vecs[i].exp_done == 1) begin
        check("vec_done_latency", 32'(done_cyc - last_adv_cyc), 32'd1);
        check("vec_idle_line", 32'(serial_out), 32'd1);
      end else begin
        check("vec_und_ready", 32'(und_ready), 32'd1);
        check("vec_und_idle_line", 32'(serial_out), 32'd1);
      end
    end

    // back-to-back bytes 0xFF then 0x3C (last)
    clear_mon();
    send_byte(8'hFF, 1'b0);
    send_byte(8'h3C, 1'b1);
    @(negedge clk);
    check("b2b_ready_low", 32'(tx_byte_ready), 32'd0);
    wait_events(1);
    check("b2b_bits", stream, 32'h0000_3CFF);
    check("b2b_nbits", 32'(nbits), 32'd16);
    check("b2b_done", 32'(done_cnt), 32'd1);
    check("b2b_underrun", 32'(und_cnt), 32'd0);
    check("b2b_gapless", 32'(act_fall), 32'd1);

    // stuffing on the strobe after the 6th advance
    clear_mon();
    stuff_at = 6;
    stuff_arm = 1'b1;
    send_byte(8'hFF, 1'b1);
    wait_events(1);
    check("stuff_bits", 32'(stream[7:0]), 32'h0000_00FF);
    check("stuff_nbits", 32'(nbits), 32'd8);
    check("stuff_strobes", 32'(strobes_act), 32'd9);
    check("stuff_hold_bit", 32'(stuff_bit), 32'd1);
    check("stuff_done_latency", 32'(done_cyc - last_adv_cyc), 32'd1);

    // ready held low after last byte until tx_done, then 0x55 accepted
    clear_mon();
    send_byte(8'h0F, 1'b1);
    tx_byte = 8'h55; tx_last = 1'b1; tx_byte_valid = 1'b1;
    early = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
      if (!tx_done && tx_byte_ready) early = 1'b1;
    end while (!tx_done && t < 500);
    check("hold_ready_early", 32'(early), 32'd0);
    check("hold_ready_at_done", 32'(tx_byte_ready), 32'd1);
    @(posedge clk); #1;
    tx_byte_valid = 1'b0;
    @(negedge clk);
    check("hold_ready_after_accept", 32'(tx_byte_ready), 32'd0);
    wait_events(2);
    check("hold_bits", stream, 32'h0000_550F);
    check("hold_done", 32'(done_cnt), 32'd2);

    // reset at bit 3 of 0xC3, then a fresh byte
    clear_mon();
    send_byte(8'hC3, 1'b1);
    t = 0;
    while (adv_cnt < 3 && t < 500) begin
      @(negedge clk); #1;
      t++;
    end
    check("rst_mid_reached", 32'(adv_cnt), 32'd3);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_serial_out", 32'(serial_out), 32'd1);
    check("rst_mid_tx_active", 32'(tx_active), 32'd0);
    check("rst_mid_ready", 32'(tx_byte_ready), 32'd1);
    repeat (80) @(negedge clk);
    #1;
    check("rst_mid_no_done", 32'(done_cnt), 32'd0);
    check("rst_mid_no_underrun", 32'(und_cnt), 32'd0);
    clear_mon();
    send_byte(8'h96, 1'b1);
    wait_events(1);
    check("rst_fresh_bits", 32'(stream[7:0]), 32'h0000_0096);
    check("rst_fresh_done", 32'(done_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
